// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - RV32I decode types, opcodes and control bundle for decode_stage
package params_pkg;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [11:0] FUNCT12_ECALL  = 12'h000;
  localparam logic [11:0] FUNCT12_EBREAK = 12'h001;
  localparam logic [11:0] FUNCT12_MRET   = 12'h302;
  localparam logic [11:0] FUNCT12_WFI    = 12'h105;

  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef enum logic [3:0] {
    CF_NONE, CF_BEQ, CF_BNE, CF_BLT, CF_BGE, CF_BLTU, CF_BGEU, CF_JAL, CF_JALR
  } cf_op_t;

  typedef enum logic [2:0] {CSR_NONE, CSR_WRITE, CSR_SET, CSR_CLEAR, CSR_READ} csr_op_t;

  // M-extension members stay contiguous in funct3 order (MUL + funct3).
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_control_t;

  typedef enum logic [1:0] {ALU_A_RS1, ALU_A_PC, ALU_A_ZERO} alu_a_sel_t;
  typedef enum logic [1:0] {ALU_B_RS2, ALU_B_IMM, ALU_B_FOUR} alu_b_sel_t;
  typedef enum logic {PC_ALU_PC, PC_ALU_RS1} pc_alu_sel_t;
  typedef enum logic {CSR_MASK_RS1, CSR_MASK_ZIMM} csr_bitmask_sel_t;

  typedef enum logic {ST_RUN, ST_HOLD} stage_state_t;

  typedef struct packed {
    logic             rd_valid;
    logic             rs1_valid;
    logic             rs2_valid;
    mem_op_t          mem_op;
    cf_op_t           cf_op;
    csr_op_t          csr_op;
    alu_control_t     alu_control;
    alu_a_sel_t       alu_a_sel;
    alu_b_sel_t       alu_b_sel;
    pc_alu_sel_t      pc_alu_sel;
    csr_bitmask_sel_t csr_bitmask_sel;
    logic             is_mret;
    logic             is_wfi;
    logic             is_fence;
    logic             illegal;
    logic             ecall_m;
    logic             breakpoint;
  } decoded_ctrl_t;

  function automatic alu_control_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - DEPTH-entry circular buffer with push/pop/flush and occupancy count
module decode_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           data_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("decode_queue: DEPTH must be a power of two >= 2");
  end

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  // Power-of-two DEPTH lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (pop_i) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with trap-hold FSM
// Optional M-extension decode enabled by defining DECODE_M_EXT_EN.
module decode_stage
  import params_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_instr_i,
  input  logic [XLEN-1:0]        in_pc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        out_pc_o,
  output logic [XLEN-1:0]        out_imm_o,
  output logic [4:0]             out_rs1_addr_o,
  output logic [4:0]             out_rs2_addr_o,
  output logic [4:0]             out_rd_addr_o,
  output decoded_ctrl_t          out_ctrl_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = 2 * XLEN + 15 + $bits(decoded_ctrl_t);

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_stage: XLEN must be 32");
  end

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh, w_imm_z;
  logic [XLEN-1:0] w_imm;
  decoded_ctrl_t   w_ctrl;
  logic            w_illegal;
  logic            w_hold_trig;
  logic            w_push, w_pop;
  logic [CW-1:0]   w_count;
  logic [W-1:0]    w_head;
  stage_state_t    r_state, w_state_nxt;

  assign w_opcode = in_instr_i[6:0];
  assign w_f3     = in_instr_i[14:12];
  assign w_f7     = in_instr_i[31:25];
  assign w_rs1    = in_instr_i[19:15];
  assign w_rs2    = in_instr_i[24:20];
  assign w_rd     = in_instr_i[11:7];

  assign w_imm_i  = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
  assign w_imm_s  = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
  assign w_imm_b  = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7], in_instr_i[30:25],
                     in_instr_i[11:8], 1'b0};
  assign w_imm_u  = {in_instr_i[31:12], 12'b0};
  assign w_imm_j  = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12], in_instr_i[20],
                     in_instr_i[30:21], 1'b0};
  assign w_imm_sh = {27'b0, in_instr_i[24:20]};
  assign w_imm_z  = {27'b0, in_instr_i[19:15]};

  always_comb begin
    w_ctrl    = '0;
    w_imm     = '0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPCODE_LOAD: begin
        w_ctrl.rd_valid  = 1'b1;
        w_ctrl.rs1_valid = 1'b1;
        w_ctrl.alu_b_sel = ALU_B_IMM;
        w_imm            = w_imm_i;
        case (w_f3)
          3'b000:  w_ctrl.mem_op = MEM_LB;
          3'b001:  w_ctrl.mem_op = MEM_LH;
          3'b010:  w_ctrl.mem_op = MEM_LW;
          3'b100:  w_ctrl.mem_op = MEM_LBU;
          3'b101:  w_ctrl.mem_op = MEM_LHU;
          default: w_illegal = 1'b1;
        endcase
      end
      OPCODE_STORE: begin
        w_ctrl.rs1_valid = 1'b1;
        w_ctrl.rs2_valid = 1'b1;
        w_ctrl.alu_b_sel = ALU_B_IMM;
        w_imm            = w_imm_s;
        case (w_f3)
          3'b000:  w_ctrl.mem_op = MEM_SB;
          3'b001:  w_ctrl.mem_op = MEM_SH;
          3'b010:  w_ctrl.mem_op = MEM_SW;
          default: w_illegal = 1'b1;
        endcase
      end
      OPCODE_BRANCH: begin
        w_ctrl.rs1_valid   = 1'b1;
        w_ctrl.rs2_valid   = 1'b1;
        w_ctrl.alu_control = ALU_SUB;
        w_imm              = w_imm_b;
        case (w_f3)
          3'b000:  w_ctrl.cf_op = CF_BEQ;
          3'b001:  w_ctrl.cf_op = CF_BNE;
          3'b100:  w_ctrl.cf_op = CF_BLT;
          3'b101:  w_ctrl.cf_op = CF_BGE;
          3'b110:  w_ctrl.cf_op = CF_BLTU;
          3'b111:  w_ctrl.cf_op = CF_BGEU;
          default: w_illegal = 1'b1;
        endcase
      end
      OPCODE_JAL, OPCODE_JALR: begin
        w_ctrl.rd_valid   = 1'b1;
        w_ctrl.alu_a_sel  = ALU_A_PC;
        w_ctrl.alu_b_sel  = ALU_B_FOUR;
        w_ctrl.cf_op      = w_opcode[3] ? CF_JAL : CF_JALR;
        w_ctrl.rs1_valid  = ~w_opcode[3];
        w_ctrl.pc_alu_sel = w_opcode[3] ? PC_ALU_PC : PC_ALU_RS1;
        w_imm             = w_opcode[3] ? w_imm_j : w_imm_i;
        if (!w_opcode[3] && w_f3 != 3'b000) w_illegal = 1'b1;
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        w_ctrl.rd_valid  = 1'b1;
        w_ctrl.alu_a_sel = w_opcode[5] ? ALU_A_ZERO : ALU_A_PC;
        w_ctrl.alu_b_sel = ALU_B_IMM;
        w_imm            = w_imm_u;
      end
      OPCODE_OP_IMM: begin
        w_ctrl.rd_valid    = 1'b1;
        w_ctrl.rs1_valid   = 1'b1;
        w_ctrl.alu_b_sel   = ALU_B_IMM;
        w_ctrl.alu_control = alu_from_funct3(w_f3, (w_f3 == 3'b101) && w_f7[5]);
        w_imm              = (w_f3[1:0] == 2'b01) ? w_imm_sh : w_imm_i;
        if (((w_f3 == 3'b001) && (w_f7 != 7'b0)) ||
            ((w_f3 == 3'b101) && ((w_f7 & 7'b1011111) != 7'b0))) w_illegal = 1'b1;
      end
      OPCODE_OP: begin
        w_ctrl.rd_valid  = 1'b1;
        w_ctrl.rs1_valid = 1'b1;
        w_ctrl.rs2_valid = 1'b1;
        if (w_f7 == 7'b0)
          w_ctrl.alu_control = alu_from_funct3(w_f3, 1'b0);
        else if ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))
          w_ctrl.alu_control = alu_from_funct3(w_f3, 1'b1);
`ifdef DECODE_M_EXT_EN
        else if (w_f7 == 7'b0000001)
          w_ctrl.alu_control = alu_control_t'(5'(ALU_MUL) + 5'(w_f3));
`endif
        else
          w_illegal = 1'b1;
      end
      OPCODE_MISC_MEM: begin
        w_ctrl.is_fence = 1'b1;
        if (w_f3[2:1] != 2'b00) w_illegal = 1'b1;
      end
      OPCODE_SYSTEM: begin
        if (w_f3 == 3'b000) begin
          if ((w_rs1 != 5'd0) || (w_rd != 5'd0)) w_illegal = 1'b1;
          else begin
            case (in_instr_i[31:20])
              FUNCT12_ECALL:  w_ctrl.ecall_m    = 1'b1;
              FUNCT12_EBREAK: w_ctrl.breakpoint = 1'b1;
              FUNCT12_MRET:   w_ctrl.is_mret    = 1'b1;
              FUNCT12_WFI:    w_ctrl.is_wfi     = 1'b1;
              default:        w_illegal         = 1'b1;
            endcase
          end
        end else if (w_f3 == 3'b100) begin
          w_illegal = 1'b1;
        end else begin
          // Set/clear with a zero source never modifies the CSR, so it is a pure read.
          w_ctrl.rd_valid        = 1'b1;
          w_ctrl.rs1_valid       = ~w_f3[2];
          w_ctrl.csr_bitmask_sel = w_f3[2] ? CSR_MASK_ZIMM : CSR_MASK_RS1;
          w_imm                  = w_f3[2] ? w_imm_z : w_imm_i;
          case (w_f3[1:0])
            2'b10:   w_ctrl.csr_op = (w_rs1 == 5'd0) ? CSR_READ : CSR_SET;
            2'b11:   w_ctrl.csr_op = (w_rs1 == 5'd0) ? CSR_READ : CSR_CLEAR;
            default: w_ctrl.csr_op = CSR_WRITE;
          endcase
        end
      end
      default: w_illegal = 1'b1;
    endcase
    if (in_instr_i[1:0] != 2'b11) w_illegal = 1'b1;
    if (w_illegal) begin
      w_ctrl         = '0;
      w_ctrl.illegal = 1'b1;
    end
  end

  assign w_hold_trig = w_ctrl.illegal | w_ctrl.ecall_m | w_ctrl.breakpoint |
                       w_ctrl.is_mret | w_ctrl.is_wfi;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    case (r_state)
      ST_RUN: begin
        in_ready_o = (w_count < CW'(DEPTH)) & ~flush_i;
        if (in_valid_i & in_ready_o & w_hold_trig) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: if (flush_i) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_push      = in_valid_i & in_ready_o;
  assign out_valid_o = (w_count != '0);
  assign w_pop       = out_valid_o & out_ready_i;
  assign count_o     = w_count;

  decode_queue #(.DEPTH(DEPTH), .W(W)) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  ({in_pc_i, w_imm, w_rs1, w_rs2, w_rd, w_ctrl}),
    .data_o  (w_head),
    .count_o (w_count)
  );

  assign {out_pc_o, out_imm_o, out_rs1_addr_o, out_rs2_addr_o, out_rd_addr_o, out_ctrl_o} = w_head;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage against a queue model
module tb_decode_stage;
  import params_pkg::*;

  localparam int DEPTH = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [31:0]   in_instr_i = '0;
  logic [31:0]   in_pc_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [31:0]   out_pc_o, out_imm_o;
  logic [4:0]    out_rs1_addr_o, out_rs2_addr_o, out_rd_addr_o;
  decoded_ctrl_t out_ctrl_o;
  logic [1:0]    count_o;

  decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_imm_o(out_imm_o),
    .out_rs1_addr_o(out_rs1_addr_o), .out_rs2_addr_o(out_rs2_addr_o), .out_rd_addr_o(out_rd_addr_o),
    .out_ctrl_o(out_ctrl_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]   instr;
    logic [31:0]   pc;
    decoded_ctrl_t ctrl;
    logic [31:0]   imm;
    logic          chk_imm;
    logic          chk_addr;
    logic [4:0]    rd, rs1, rs2;
  } exp_t;

  exp_t mq[$];
  bit   m_hold = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit traps(input decoded_ctrl_t c);
    return c.illegal | c.ecall_m | c.breakpoint | c.is_mret | c.is_wfi;
  endfunction

  function automatic exp_t gen(input int kind);
    exp_t e;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [19:0] u20;
    logic [4:0]  rd, rs1, rs2;
    int          sub;
    e = '{default: '0};
    i12 = 12'($urandom); b13 = {12'($urandom), 1'b0}; j21 = {20'($urandom), 1'b0};
    u20 = 20'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    e.pc = 32'($urandom) & 32'hFFFF_FFFC;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.chk_imm = 1'b1; e.chk_addr = 1'b1;
    case (kind)
      0: begin
        e.instr = {i12, rs1, 3'b000, rd, 7'b0010011};
        e.rs2 = i12[4:0];
        e.ctrl.rd_valid = 1; e.ctrl.rs1_valid = 1; e.ctrl.alu_b_sel = ALU_B_IMM;
        e.imm = 32'($signed(i12));
      end
      1: begin
        logic [2:0] f3; logic [6:0] f7; alu_control_t a;
        sub = $urandom_range(0, 4);
        case (sub)
          0: begin f3 = 3'd0; f7 = 7'h00; a = ALU_ADD; end
          1: begin f3 = 3'd0; f7 = 7'h20; a = ALU_SUB; end
          2: begin f3 = 3'd4; f7 = 7'h00; a = ALU_XOR; end
          3: begin f3 = 3'd5; f7 = 7'h20; a = ALU_SRA; end
          default: begin f3 = 3'd7; f7 = 7'h00; a = ALU_AND; end
        endcase
        e.instr = {f7, rs2, rs1, f3, rd, 7'b0110011};
        e.ctrl.rd_valid = 1; e.ctrl.rs1_valid = 1; e.ctrl.rs2_valid = 1; e.ctrl.alu_control = a;
        e.chk_imm = 0;
      end
      2: begin
        e.instr = {i12, rs1, 3'b010, rd, 7'b0000011};
        e.rs2 = i12[4:0];
        e.ctrl.rd_valid = 1; e.ctrl.rs1_valid = 1; e.ctrl.alu_b_sel = ALU_B_IMM; e.ctrl.mem_op = MEM_LW;
        e.imm = 32'($signed(i12));
      end
      3: begin
        e.instr = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'b0100011};
        e.rd = i12[4:0];
        e.ctrl.rs1_valid = 1; e.ctrl.rs2_valid = 1; e.ctrl.alu_b_sel = ALU_B_IMM; e.ctrl.mem_op = MEM_SW;
        e.imm = 32'($signed(i12));
      end
      4: begin
        sub = $urandom_range(0, 1);
        e.instr = {b13[12], b13[10:5], rs2, rs1, 2'b00, 1'(sub), b13[4:1], b13[11], 7'b1100011};
        e.rd = {b13[4:1], b13[11]};
        e.ctrl.rs1_valid = 1; e.ctrl.rs2_valid = 1; e.ctrl.alu_control = ALU_SUB;
        e.ctrl.cf_op = (sub == 0) ? CF_BEQ : CF_BNE;
        e.imm = 32'($signed(b13));
      end
      5: begin
        e.instr = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'b1101111};
        e.chk_addr = 0;
        e.ctrl.rd_valid = 1; e.ctrl.cf_op = CF_JAL; e.ctrl.alu_a_sel = ALU_A_PC; e.ctrl.alu_b_sel = ALU_B_FOUR;
        e.imm = 32'($signed(j21));
      end
      6: begin
        e.instr = {u20, rd, 7'b0110111};
        e.chk_addr = 0;
        e.ctrl.rd_valid = 1; e.ctrl.alu_a_sel = ALU_A_ZERO; e.ctrl.alu_b_sel = ALU_B_IMM;
        e.imm = 32'(u20) * 32'd4096;
      end
      7: begin
        if ($urandom_range(0, 1) == 0) rs1 = 5'd0;
        e.rs1 = rs1; e.rs2 = i12[4:0];
        e.instr = {i12, rs1, 3'b010, rd, 7'b1110011};
        e.ctrl.rd_valid = 1; e.ctrl.rs1_valid = 1;
        e.ctrl.csr_op = (rs1 == 5'd0) ? CSR_READ : CSR_SET;
        e.imm = 32'($signed(i12));
      end
      8: begin
        e.instr = {i12, rs1, 3'b101, rd, 7'b1110011};
        e.rs2 = i12[4:0];
        e.ctrl.rd_valid = 1; e.ctrl.csr_op = CSR_WRITE; e.ctrl.csr_bitmask_sel = CSR_MASK_ZIMM;
        e.imm = 32'(rs1);
      end
      9: begin
        e.instr = {7'b0, rs2, rs1, 3'b001, rd, 7'b0010011};
        e.ctrl.rd_valid = 1; e.ctrl.rs1_valid = 1; e.ctrl.alu_b_sel = ALU_B_IMM; e.ctrl.alu_control = ALU_SLL;
        e.imm = 32'(rs2);
      end
      10: begin
        e.instr = {4'b0, 8'($urandom), 5'b0, 3'b000, 5'b0, 7'b0001111};
        e.ctrl.is_fence = 1; e.chk_imm = 0; e.chk_addr = 0;
      end
      11: begin e.instr = 32'h0000_0073; e.ctrl.ecall_m = 1; e.chk_imm = 0; e.chk_addr = 0; end
      12: begin e.instr = 32'hFFFF_FFFF; e.ctrl.illegal = 1; e.chk_imm = 0; e.chk_addr = 0; end
      13: begin e.instr = 32'h3020_0073; e.ctrl.is_mret = 1; e.chk_imm = 0; e.chk_addr = 0; end
      14: begin e.instr = 32'h1050_0073; e.ctrl.is_wfi = 1; e.chk_imm = 0; e.chk_addr = 0; end
      default: begin
        e.instr = {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
        e.chk_imm = 0;
`ifdef DECODE_M_EXT_EN
        e.ctrl.rd_valid = 1; e.ctrl.rs1_valid = 1; e.ctrl.rs2_valid = 1; e.ctrl.alu_control = ALU_MUL;
`else
        e.ctrl.illegal = 1; e.chk_addr = 0;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic check_outputs();
    check("out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
    check("count", 64'(count_o), 64'(mq.size()));
    if (mq.size() != 0) begin
      check("pc", 64'(out_pc_o), 64'(mq[0].pc));
      check("ctrl", 64'(out_ctrl_o), 64'(mq[0].ctrl));
      if (mq[0].chk_imm) check("imm", 64'(out_imm_o), 64'(mq[0].imm));
      if (mq[0].chk_addr)
        check("addrs", 64'({out_rd_addr_o, out_rs1_addr_o, out_rs2_addr_o}),
              64'({mq[0].rd, mq[0].rs1, mq[0].rs2}));
    end
  endtask

  task automatic step(input logic fl, input logic vld, input exp_t e, input logic rdy);
    bit exp_rdy;
    @(negedge clk_i);
    check_outputs();
    flush_i = fl; in_valid_i = vld; in_instr_i = e.instr; in_pc_i = e.pc; out_ready_i = rdy;
    #1;
    exp_rdy = (mq.size() < DEPTH) && !m_hold && !fl;
    check("in_ready", 64'(in_ready_o), 64'(exp_rdy));
    if (fl) begin
      mq.delete();
      m_hold = 1'b0;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (vld && exp_rdy) begin
        mq.push_back(e);
        if (traps(e.ctrl)) m_hold = 1'b1;
      end
    end
  endtask

  exp_t idle, e_addi, ea, eb, ec;

  initial begin
    idle = '{default: '0};
    #7;
    check("reset out_valid", 64'(out_valid_o), 64'd0);
    check("reset count", 64'(count_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("reset in_ready", 64'(in_ready_o), 64'd1);
    check("reset payload", 64'({out_pc_o, out_imm_o}), 64'd0);
    check("reset ctrl", 64'(out_ctrl_o), 64'd0);

    e_addi = '{default: '0};
    e_addi.instr = 32'h0050_0093; e_addi.pc = 32'h100; e_addi.imm = 32'd5;
    e_addi.rd = 5'd1; e_addi.rs1 = 5'd0; e_addi.rs2 = 5'd5; e_addi.chk_imm = 1; e_addi.chk_addr = 1;
    e_addi.ctrl.rd_valid = 1; e_addi.ctrl.rs1_valid = 1; e_addi.ctrl.alu_b_sel = ALU_B_IMM;
    e_addi.ctrl.alu_control = ALU_ADD;
    step(0, 1, e_addi, 1);
    step(0, 0, idle, 1);
    step(0, 0, idle, 1);

    ea = gen(0); eb = gen(2); ec = gen(3);
    step(0, 1, ea, 0);
    step(0, 1, eb, 0);
    step(0, 1, ec, 0);
    step(0, 1, ec, 1);
    step(0, 1, ec, 0);
    step(0, 0, idle, 1);
    step(0, 0, idle, 1);
    step(0, 0, idle, 1);

    step(0, 1, gen(11), 0);
    step(0, 1, e_addi, 0);
    step(0, 1, e_addi, 1);
    step(1, 1, e_addi, 0);
    step(0, 0, idle, 0);

    step(0, 1, gen(12), 1);
    step(0, 0, idle, 1);
    step(1, 0, idle, 0);
    ea = gen(12); ea.instr = 32'h0000_0010;
    step(0, 1, ea, 0);
    step(0, 1, e_addi, 0);
    step(1, 0, idle, 0);

    ea = gen(15); ea.instr = 32'h0220_81B3;
    step(0, 1, ea, 0);
    step(0, 0, idle, 1);
    step(1, 0, idle, 0);

    step(0, 1, gen(0), 0);
    step(0, 1, gen(9), 0);
    @(negedge clk_i);
    check("prereset count", 64'(count_o), 64'd2);
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("async rst out_valid", 64'(out_valid_o), 64'd0);
    check("async rst count", 64'(count_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mq.delete();
    m_hold = 1'b0;
    step(0, 0, idle, 0);

    for (int i = 0; i < 600; i++) begin
      int  kind;
      bit  fl;
      kind = ($urandom_range(0, 99) < 88) ? $urandom_range(0, 10) : $urandom_range(11, 15);
      fl = m_hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      step(fl, 1'($urandom_range(0, 9) < 7), gen(kind), 1'($urandom_range(0, 9) < 6));
    end
    step(0, 0, idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I decode stage with a valid/ready handshake on both sides. Each accepted instruction word is decoded combinationally (control bundle, register addresses, sign-extended immediate) and pushed into a DEPTH-entry circular queue feeding issue/execute. Adds MRET/WFI/FENCE decode and a trap-hold state machine that stalls fetch after a trapping instruction until the pipeline is flushed.

Parameters:
- XLEN, 32: PC and immediate width (32 only legal value today; checked by assertion).
- DEPTH, 2: queue entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush: drop all queued entries and leave trap-hold.
- in_valid_i  in  1  fetch presents instruction.
- in_ready_o  out  1  stage accepts this cycle.
- in_instr_i  in  32  raw instruction word.
- in_pc_i  in  XLEN  PC of instruction.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer takes head.
- out_pc_o  out  XLEN  head PC.
- out_imm_o  out  XLEN  head extended immediate.
- out_rs1_addr_o / out_rs2_addr_o / out_rd_addr_o  out  5 each  head register addresses.
- out_ctrl_o  out  $bits(decoded_ctrl_t)  head control bundle: rd/rs1/rs2 valid, mem_op, cf_op, csr_op, alu_control, alu_a/b sel, pc_alu sel, csr_bitmask sel, is_mret, is_wfi, is_fence, trap flags (illegal, ecall_m, breakpoint).
- count_o  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst_ni low, async): queue pointers 0, count_o 0, out_valid_o 0, FSM RUN. in_ready_o 1 once reset deasserts. Payload outputs are don't-care while out_valid_o = 0; drive 0 after reset.
- Push when in_valid_i & in_ready_o. Pop when out_valid_o & out_ready_i.
- Latency: 1 cycle. An entry pushed at edge N is visible at the head after edge N when the queue was empty. No combinational path from in_* to out_*.
- in_ready_o = (count < DEPTH) & (state == RUN) & ~flush_i. A full queue with a simultaneous pop does not accept; there is no pass-through.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Decode rules: standard RV32I control mapping (loads, stores, branches, JAL, JALR, LUI, AUIPC, OP, OP-IMM, SYSTEM/CSR).
  - CSRRS/CSRRC and immediate variants with rs1 = 0 give CSR_READ.
  - SYSTEM funct3 = 0 with rs1 = rd = 0: funct12 0x000 is ECALL, 0x001 is EBREAK, 0x302 is MRET, 0x105 is WFI; any other value is illegal.
  - MISC-MEM (0001111), FENCE and FENCE.I, decode as NOP with is_fence = 1 and no register valids.
  - in_instr_i[1:0] != 2'b11 is illegal.
  - Any trapping entry clears rd/rs1/rs2 valid and sets mem_op = MEM_NONE, cf_op = CF_NONE, csr_op = CSR_NONE.
  - Trap flags are mutually exclusive; illegal has priority.
- Immediate: I/S/B/U/J/shamt/CSR-zimm formats, sign-extended to XLEN. CSR zimm is zero-extended.
- FSM:
  - RUN: a push of an entry with any trap flag, is_mret or is_wfi moves to HOLD.
  - HOLD: in_ready_o = 0 and the queue keeps draining. flush_i returns to RUN.
- flush_i: next edge count = 0, pointers = 0, state RUN. A pop in the same cycle has no additional effect. Flush beats push: in_ready_o is forced low.
- Reset mid-operation discards all entries immediately (async).

Optional Feature:
- DECODE_M_EXT_EN defined: OP with funct7 = 0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU into new alu_control values, with rs1/rs2/rd valid.
- Not defined: funct7 = 0000001 on OP is illegal.

Decomposition:
- params_pkg gains:
  - decoded_ctrl_t packed struct.
  - OPCODE_MISC_MEM, FUNCT12_MRET, FUNCT12_WFI.
  - M-extension alu_control_t members (always declared, only produced under the macro).
- Sub-module decode_queue: parametrised DEPTH circular buffer of {pc, imm, addrs, ctrl} with push/pop/flush and count. Decode logic stays inline in decode_stage.

Test Plan:
- Push ADDI x1,x0,5 (0x00500093, pc 0x100) into an empty queue with out_ready_i = 1. Next cycle: out_valid_o = 1, rd = 1, imm = 5, ALU add, alu_b sel IMM, count_o = 1.
- out_ready_i = 0 with 3 back-to-back pushes, DEPTH 2. in_ready_o drops after 2 accepts. Raise out_ready_i with in_valid_i held: the full cycle pops without pushing, and the third instruction is accepted the next cycle. FIFO order is preserved.
- Push ECALL (0x00000073), then ADDI. ECALL is queued with ecall_m = 1 and all valids 0, the FSM enters HOLD, and in_ready_o = 0 until flush_i. After flush: count_o = 0, in_ready_o = 1.
- Push 0xFFFFFFFF and 0x00000013 with bits[1:0] altered to 00. Both give illegal = 1; each push enters HOLD.
- MUL x3,x1,x2 (0x022081B3): with DECODE_M_EXT_EN the MUL alu_control is set and illegal = 0; without it illegal = 1.
- Pulse rst_ni low mid-stream with count = 2. out_valid_o drops immediately; after release, count_o = 0 and in_ready_o = 1.
